// File: rtl/snoop_pkg.sv
// Shared types for the ACE snoop responder: AC snoop codes, CR response
// layout, controller states and the coherence flag triple written back.
package snoop_pkg;

    // ACSNOOP encodings seen on the AC channel (DVM codes are not serviced here)
    typedef enum logic [3:0] {
        READ_ONCE             = 4'b0000,
        READ_SHARED           = 4'b0001,
        READ_CLEAN            = 4'b0010,
        READ_NOT_SHARED_DIRTY = 4'b0011,
        READ_UNIQUE           = 4'b0111,
        CLEAN_SHARED          = 4'b1000,
        CLEAN_INVALID         = 4'b1001,
        MAKE_INVALID          = 4'b1101,
        DVM_COMPLETE          = 4'b1110,
        DVM_MESSAGE           = 4'b1111
    } acsnoop_t;

    // CRRESP[4:0] = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EVAL,
        ST_UPDATE,
        ST_SEND_CR,
        ST_SEND_CD
    } snp_state_e;

    // Flag values written into the hit way on a coherence update
    typedef struct packed {
        logic valid;
        logic dirty;
        logic shared;
    } flags_t;

    // Codes this responder looks up in the cache; anything else errors out
    function automatic logic snoop_supported(acsnoop_t s);
        case (s)
            READ_ONCE, READ_SHARED, READ_CLEAN, READ_NOT_SHARED_DIRTY,
            READ_UNIQUE, CLEAN_SHARED, CLEAN_INVALID, MAKE_INVALID: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/snoop_resp_ctrl_if.sv
// ACE snoop channel bundle (AC request, CR response, CD data).
// master = interconnect side, slave = cache snoop responder.
interface snoop_resp_ctrl_if #(
    parameter int ADDR_W = 56,
    parameter int CD_W   = 64
) ();

    logic                 ac_valid;
    logic                 ac_ready;
    logic [ADDR_W-1:0]    ac_addr;
    snoop_pkg::acsnoop_t  ac_snoop;

    logic                 cr_valid;
    logic                 cr_ready;
    snoop_pkg::crresp_t   cr_resp;

    logic                 cd_valid;
    logic                 cd_ready;
    logic [CD_W-1:0]      cd_data;
    logic                 cd_last;

    modport master (
        output ac_valid, ac_addr, ac_snoop, cr_ready, cd_ready,
        input  ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last
    );

    modport slave (
        input  ac_valid, ac_addr, ac_snoop, cr_ready, cd_ready,
        output ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last
    );

endinterface

// File: rtl/snoop_cd_serializer.sv
// Holds the snooped line and streams it out as LINE_WIDTH/CD_WIDTH beats,
// lowest beat first. The beat counter only moves on an accepted beat.
module snoop_cd_serializer #(
    parameter int LINE_WIDTH = 128,
    parameter int CD_WIDTH   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [LINE_WIDTH-1:0] line_i,
    input  logic                  clear_i,
    input  logic                  send_i,
    output logic                  cd_valid_o,
    input  logic                  cd_ready_i,
    output logic [CD_WIDTH-1:0]   cd_data_o,
    output logic                  cd_last_o,
    output logic                  done_o
);

    localparam int BEATS  = LINE_WIDTH / CD_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BEATS-1:0][CD_WIDTH-1:0] line_q;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic                           accept;

    assign cd_valid_o = send_i;
    assign cd_data_o  = line_q[beat_q];
    assign cd_last_o  = (beat_q == BEAT_W'(BEATS - 1));
    assign accept     = send_i & cd_ready_i;
    assign done_o     = accept & cd_last_o;

    // Next beat: restart on a new snoop or after the last beat, else step on accept
    always_comb begin
        beat_d = beat_q;
        if (clear_i) begin
            beat_d = '0;
        end else if (accept) begin
            beat_d = cd_last_o ? '0 : beat_q + 1'b1;
        end
    end

    // Line capture and beat counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
            if (load_i) begin
                line_q <= line_i;
            end
        end
    end

endmodule

// File: rtl/snoop_resp_ctrl.sv
// ACE snoop responder for the data cache: accepts one AC snoop, looks the
// line up through the SRAM arbiter port, rewrites the hit way's coherence
// flags where the snoop demands it, then answers on CR and streams the line
// on CD when DataTransfer is set.
module snoop_resp_ctrl
    import snoop_pkg::*;
#(
    parameter int NR_WAYS     = 8,
    parameter int INDEX_WIDTH = 12,
    parameter int TAG_WIDTH   = 44,
    parameter int LINE_WIDTH  = 128,
    parameter int CD_WIDTH    = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 bypass_i,
    output logic                                 busy_o,
    snoop_resp_ctrl_if.slave                     snp,
    output logic [NR_WAYS-1:0]                   req_o,
    output logic [INDEX_WIDTH-1:0]               addr_o,
    output logic [TAG_WIDTH-1:0]                 tag_o,
    input  logic                                 gnt_i,
    output logic                                 we_o,
    output logic [NR_WAYS-1:0]                   be_vldrty_o,
    output logic                                 wr_valid_o,
    output logic                                 wr_dirty_o,
    output logic                                 wr_shared_o,
    input  logic [NR_WAYS-1:0][LINE_WIDTH-1:0]   data_i,
    input  logic [NR_WAYS-1:0]                   hit_way_i,
    input  logic [NR_WAYS-1:0]                   dirty_way_i,
    input  logic [NR_WAYS-1:0]                   shared_way_i,
    output logic [INDEX_WIDTH+TAG_WIDTH-1:0]     mshr_addr_o,
    input  logic                                 mshr_index_matches_i
);

    localparam int ADDR_W = INDEX_WIDTH + TAG_WIDTH;

    snp_state_e          state_q;
    logic [ADDR_W-1:0]   addr_q;
    acsnoop_t            snoop_q;
    crresp_t             cr_q;
    logic [NR_WAYS-1:0]  hit_way_q;
    flags_t              flags_q;

    logic                idle;
    logic                ac_hs;
    logic                sram_ok;
    logic [ADDR_W-1:0]   cur_addr;
    logic                lookup_hit;
    logic                hit_dirty;
    logic                hit_shared;
    logic [LINE_WIDTH-1:0] hit_line_d;
    crresp_t             eval_cr_d;
    logic                eval_upd_d;
    flags_t              eval_flags_d;
    logic                cd_done;

    assign idle     = (state_q == ST_IDLE);
    assign busy_o   = ~idle;

    // New snoops are held off during a flush or while the miss unit owns the index
    assign snp.ac_ready = idle & ~flush_i & ~mshr_index_matches_i;
    assign ac_hs        = snp.ac_valid & snp.ac_ready;
    assign sram_ok      = ~bypass_i & snoop_supported(snp.ac_snoop);

    // While idle the SRAM/MSHR address follows the AC bus so the lookup can start
    // in the handshake cycle; afterwards it is the latched snoop address.
    assign cur_addr    = idle ? snp.ac_addr : addr_q;
    assign mshr_addr_o = cur_addr;
    assign addr_o      = cur_addr[INDEX_WIDTH-1:0];
    assign tag_o       = cur_addr[ADDR_W-1:INDEX_WIDTH];

    assign we_o        = (state_q == ST_UPDATE);
    assign be_vldrty_o = we_o ? hit_way_q : '0;
    assign wr_valid_o  = we_o & flags_q.valid;
    assign wr_dirty_o  = we_o & flags_q.dirty;
    assign wr_shared_o = we_o & flags_q.shared;

    assign snp.cr_valid = (state_q == ST_SEND_CR);
    assign snp.cr_resp  = snp.cr_valid ? cr_q : '0;

    // SRAM request: all ways for the lookup, only the hit way for the flag write
    always_comb begin
        req_o = '0;
        case (state_q)
            ST_IDLE:   if (ac_hs && sram_ok) req_o = '1;
            ST_LOOKUP: req_o = '1;
            ST_UPDATE: req_o = hit_way_q;
            default:   req_o = '0;
        endcase
    end

    assign lookup_hit = |hit_way_i;
    assign hit_dirty  = |(dirty_way_i & hit_way_i);
    assign hit_shared = |(shared_way_i & hit_way_i);

    // Select the hit way's line out of the read data (hit vector is one-hot)
    always_comb begin
        hit_line_d = '0;
        for (int w = 0; w < NR_WAYS; w++) begin
            if (hit_way_i[w]) hit_line_d = hit_line_d | data_i[w];
        end
    end

    // Response and flag rewrite for the looked-up line
    always_comb begin
        eval_cr_d    = '0;
        eval_upd_d   = 1'b0;
        eval_flags_d = '0;
        if (lookup_hit) begin
            case (snoop_q)
                READ_ONCE: begin
                    eval_cr_d.data_transfer = 1'b1;
                    eval_cr_d.is_shared     = 1'b1;
                end
                READ_SHARED, READ_CLEAN, READ_NOT_SHARED_DIRTY: begin
                    eval_cr_d.data_transfer = 1'b1;
                    eval_cr_d.pass_dirty    = hit_dirty;
                    eval_cr_d.is_shared     = 1'b1;
                    eval_upd_d              = 1'b1;
                    eval_flags_d.valid      = 1'b1;
                    eval_flags_d.shared     = 1'b1;
                end
                READ_UNIQUE: begin
                    eval_cr_d.data_transfer = 1'b1;
                    eval_cr_d.pass_dirty    = hit_dirty;
                    eval_upd_d              = 1'b1;
                end
                CLEAN_SHARED: begin
                    eval_cr_d.data_transfer = hit_dirty;
                    eval_cr_d.pass_dirty    = hit_dirty;
                    eval_cr_d.is_shared     = 1'b1;
                    eval_upd_d              = 1'b1;
                    eval_flags_d.valid      = 1'b1;
                    eval_flags_d.shared     = hit_shared;
                end
                CLEAN_INVALID: begin
                    eval_cr_d.data_transfer = hit_dirty;
                    eval_cr_d.pass_dirty    = hit_dirty;
                    eval_upd_d              = 1'b1;
                end
                MAKE_INVALID: begin
                    eval_upd_d              = 1'b1;
                end
                default: begin
                    eval_upd_d              = 1'b0;
                end
            endcase
        end
    end

    // Snoop sequencing FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            snoop_q   <= READ_ONCE;
            cr_q      <= '0;
            hit_way_q <= '0;
            flags_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ac_hs) begin
                        addr_q  <= snp.ac_addr;
                        snoop_q <= snp.ac_snoop;
                        cr_q    <= '0;
                        if (!sram_ok) begin
                            cr_q.error <= 1'b1;
                            state_q    <= ST_SEND_CR;
                        end else begin
                            state_q <= gnt_i ? ST_EVAL : ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (gnt_i) state_q <= ST_EVAL;
                end
                ST_EVAL: begin
                    cr_q <= eval_cr_d;
                    if (lookup_hit) begin
                        hit_way_q <= hit_way_i;
                        flags_q   <= eval_flags_d;
                    end
                    state_q <= eval_upd_d ? ST_UPDATE : ST_SEND_CR;
                end
                ST_UPDATE: begin
                    if (gnt_i) state_q <= ST_SEND_CR;
                end
                ST_SEND_CR: begin
                    if (snp.cr_ready) begin
                        state_q <= cr_q.data_transfer ? ST_SEND_CD : ST_IDLE;
                    end
                end
                ST_SEND_CD: begin
                    if (cd_done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    snoop_cd_serializer #(
        .LINE_WIDTH (LINE_WIDTH),
        .CD_WIDTH   (CD_WIDTH)
    ) u_cd_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     ((state_q == ST_EVAL) && lookup_hit),
        .line_i     (hit_line_d),
        .clear_i    (ac_hs),
        .send_i     (state_q == ST_SEND_CD),
        .cd_valid_o (snp.cd_valid),
        .cd_ready_i (snp.cd_ready),
        .cd_data_o  (snp.cd_data),
        .cd_last_o  (snp.cd_last),
        .done_o     (cd_done)
    );

endmodule
